timing_sequencer: RTL and testbench

//  Parametrised timing-state generator for the accumulator CPU control path. Produces the one-hot
//  T-state vector consumed by the combinational control decoder and stalls it for user input
//  (enter) and for memory-controller block transfers (STD/LDD). Counts retired instructions and

---
 rtl/timing_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_timing_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// timing_sequencer
//   Generates the one-hot T-state vector for the accumulator CPU control path.
//   It holds the vector while waiting for user input (enter) or for a memory
//   block transfer (STD/LDD), and it counts retired instructions. When
//   preemptive scheduling is enabled, it requests a context switch every
//   QUANTUM instructions.
//
//   Parameters
//     N_T        number of T-states (4..16)
//     QUANTUM_W  width of the retired-instruction counter
//     QUANTUM    instructions per time slice (1..2**QUANTUM_W)
//
//   Ports
//     clk, rst_n          clock; synchronous active-low reset
//     halt                HLT decoded, stops sequencing until reset
//     go_t0               current T is the last step of the instruction
//     in_req, enter       input request from decoder / user data present
//     tr_req, tr_dir      block transfer start, 0 = STD, 1 = LDD
//     tr_done             memory controller finished the transfer
//     sched_en, ctx_ack   scheduling enable / scheduler switched context
//     t, t_idx            one-hot T-state and its binary index
//     read                waiting for enter
//     tr_std, tr_ldd      one-cycle transfer start pulses
//     stall, halted       state != RUN / state == HALTED
//     instr_cnt           instructions retired in the current slice
//     ctx_req             context switch requested, held until ctx_ack
//
//   All outputs are registered.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   RUN     | T-state advances or retires every cycle
//   WAIT_IN | T held, read = 1, waiting for enter
//   WAIT_TR | T held, waiting for tr_done from memory controller
//   CTX     | T held at T0, ctx_req = 1, waiting for ctx_ack
//   HALTED  | t = 0, left only through reset
module timing_sequencer #(
   parameter int N_T       = 10,
   parameter int QUANTUM_W = 4,
   parameter int QUANTUM   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   halt,
   input  logic                   go_t0,
   input  logic                   in_req,
   input  logic                   enter,
   input  logic                   tr_req,
   input  logic                   tr_dir,
   input  logic                   tr_done,
   input  logic                   sched_en,
   input  logic                   ctx_ack,
   output logic [N_T-1:0]         t,
   output logic [$clog2(N_T)-1:0] t_idx,
   output logic                   read,
   output logic                   tr_std,
   output logic                   tr_ldd,
   output logic                   stall,
   output logic                   halted,
   output logic [QUANTUM_W-1:0]   instr_cnt,
   output logic                   ctx_req
);

   localparam int                   TW      = $clog2(N_T);
   localparam logic [N_T-1:0]       T0      = N_T'(1);
   localparam logic [QUANTUM_W-1:0] CNT_MAX = QUANTUM_W'(QUANTUM - 1);

   typedef enum logic [2:0] {
      RUN,
      WAIT_IN,
      WAIT_TR,
      CTX,
      HALTED
   } state_t;

   // What happens to the T-vector on the coming edge.
   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_RETIRE,
      ACT_ADVANCE,
      ACT_CLEAR
   } act_t;

   state_t                 state_q, state_d;
   act_t                   act;
   logic                   retire_pend_q, retire_pend_d;
   logic [N_T-1:0]         t_q, t_d;
   logic [TW-1:0]          t_idx_q, t_idx_d;
   logic                   read_q, read_d;
   logic                   tr_std_q, tr_std_d;
   logic                   tr_ldd_q, tr_ldd_d;
   logic                   stall_q, stall_d;
   logic                   halted_q, halted_d;
   logic [QUANTUM_W-1:0]   instr_cnt_q, instr_cnt_d;
   logic                   ctx_req_q, ctx_req_d;

   logic                   retire_now;
   logic                   quantum_end;

   // The last T-state always retires. It is folded into the pending flag, so
   // a stall taken at T(N_T-1) still wraps back to T0 afterwards.
   assign retire_now  = go_t0 | t_q[N_T-1];
   assign quantum_end = (instr_cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= RUN;
         retire_pend_q <= 1'b0;
         t_q           <= T0;
         t_idx_q       <= '0;
         read_q        <= 1'b0;
         tr_std_q      <= 1'b0;
         tr_ldd_q      <= 1'b0;
         stall_q       <= 1'b0;
         halted_q      <= 1'b0;
         instr_cnt_q   <= '0;
         ctx_req_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         retire_pend_q <= retire_pend_d;
         t_q           <= t_d;
         t_idx_q       <= t_idx_d;
         read_q        <= read_d;
         tr_std_q      <= tr_std_d;
         tr_ldd_q      <= tr_ldd_d;
         stall_q       <= stall_d;
         halted_q      <= halted_d;
         instr_cnt_q   <= instr_cnt_d;
         ctx_req_q     <= ctx_req_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      act           = ACT_HOLD;
      retire_pend_d = retire_pend_q;
      unique case (state_q)
         RUN: begin
            if (halt) begin
               state_d = HALTED;
               act     = ACT_CLEAR;
            end else if (tr_req) begin
               state_d       = WAIT_TR;
               retire_pend_d = retire_now;
            end else if (in_req && !enter) begin
               state_d       = WAIT_IN;
               retire_pend_d = retire_now;
            end else if (retire_now) begin
               act = ACT_RETIRE;
            end else begin
               act = ACT_ADVANCE;
            end
         end
         WAIT_IN: begin
            if (enter) begin
               state_d = RUN;
               act     = retire_pend_q ? ACT_RETIRE : ACT_ADVANCE;
            end
         end
         WAIT_TR: begin
            if (tr_done) begin
               state_d = RUN;
               act     = retire_pend_q ? ACT_RETIRE : ACT_ADVANCE;
            end
         end
         CTX: begin
            if (ctx_ack) begin
               state_d = RUN;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      // The retire that closes a time slice parks the sequencer at T0.
      if (act == ACT_RETIRE && quantum_end && sched_en) begin
         state_d = CTX;
      end
   end

   always_comb begin
      t_d         = t_q;
      instr_cnt_d = instr_cnt_q;
      unique case (act)
         ACT_CLEAR:   t_d = '0;
         ACT_RETIRE: begin
            t_d         = T0;
            instr_cnt_d = quantum_end ? '0 : instr_cnt_q + QUANTUM_W'(1);
         end
         ACT_ADVANCE: t_d = t_q << 1;
         default:     t_d = t_q;
      endcase

      t_idx_d = '0;
      for (int i = 0; i < N_T; i++) begin
         if (t_d[i]) begin
            t_idx_d = TW'(i);
         end
      end

      read_d    = (state_d == WAIT_IN);
      stall_d   = (state_d != RUN);
      halted_d  = (state_d == HALTED);
      ctx_req_d = (state_d == CTX);
      // The start pulses fire only on the RUN -> WAIT_TR transition, so they
      // cover exactly the first WAIT_TR cycle.
      tr_std_d  = (state_q == RUN) && (state_d == WAIT_TR) && !tr_dir;
      tr_ldd_d  = (state_q == RUN) && (state_d == WAIT_TR) && tr_dir;
   end

   assign t         = t_q;
   assign t_idx     = t_idx_q;
   assign read      = read_q;
   assign tr_std    = tr_std_q;
   assign tr_ldd    = tr_ldd_q;
   assign stall     = stall_q;
   assign halted    = halted_q;
   assign instr_cnt = instr_cnt_q;
   assign ctx_req   = ctx_req_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer
//   Directed scenarios followed by random traffic. Each cycle, the DUT is
//   compared against a reference model. The model tracks the T-state as a
//   plain integer position and the slice as a plain retire count.
module tb_timing_sequencer;

   localparam int N_T       = 10;
   localparam int QUANTUM_W = 4;
   localparam int QUANTUM   = 8;

   logic                 clk;
   logic                 rst_n, halt, go_t0, in_req, enter;
   logic                 tr_req, tr_dir, tr_done, sched_en, ctx_ack;
   logic [N_T-1:0]       t;
   logic [3:0]           t_idx;
   logic                 read, tr_std, tr_ldd, stall, halted, ctx_req;
   logic [QUANTUM_W-1:0] instr_cnt;

   int checks = 0;
   int errors = 0;

   // reference model
   int m_pos;
   int m_cnt;
   bit m_in, m_tr, m_ctx, m_halt, m_pend, m_std, m_ldd;

   timing_sequencer #(.N_T(N_T), .QUANTUM_W(QUANTUM_W), .QUANTUM(QUANTUM)) dut (
      .clk(clk), .rst_n(rst_n), .halt(halt), .go_t0(go_t0), .in_req(in_req),
      .enter(enter), .tr_req(tr_req), .tr_dir(tr_dir), .tr_done(tr_done),
      .sched_en(sched_en), .ctx_ack(ctx_ack), .t(t), .t_idx(t_idx), .read(read),
      .tr_std(tr_std), .tr_ldd(tr_ldd), .stall(stall), .halted(halted),
      .instr_cnt(instr_cnt), .ctx_req(ctx_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_finish(input bit retire);
      if (retire) begin
         m_pos = 0;
         m_cnt = m_cnt + 1;
         if (m_cnt == QUANTUM) begin
            m_cnt = 0;
            if (sched_en) m_ctx = 1;
         end
      end else begin
         m_pos = m_pos + 1;
      end
   endtask

   task automatic model_edge();
      m_std = 0;
      m_ldd = 0;
      if (!rst_n) begin
         m_pos = 0; m_cnt = 0;
         m_in = 0; m_tr = 0; m_ctx = 0; m_halt = 0; m_pend = 0;
      end else if (m_halt) begin
         m_halt = 1;
      end else if (m_ctx) begin
         if (ctx_ack) m_ctx = 0;
      end else if (m_in) begin
         if (enter) begin
            m_in = 0;
            model_finish(m_pend);
         end
      end else if (m_tr) begin
         if (tr_done) begin
            m_tr = 0;
            model_finish(m_pend);
         end
      end else if (halt) begin
         m_halt = 1;
         m_pos  = 0;
      end else if (tr_req) begin
         m_tr   = 1;
         m_pend = go_t0 || (m_pos == N_T - 1);
         if (tr_dir) m_ldd = 1; else m_std = 1;
      end else if (in_req && !enter) begin
         m_in   = 1;
         m_pend = go_t0 || (m_pos == N_T - 1);
      end else begin
         model_finish(go_t0 || (m_pos == N_T - 1));
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, "/t"},         32'(t),         m_halt ? 32'd0 : (32'd1 << m_pos));
      chk({ph, "/t_idx"},     32'(t_idx),     m_halt ? 32'd0 : 32'(m_pos));
      chk({ph, "/read"},      32'(read),      32'(m_in));
      chk({ph, "/tr_std"},    32'(tr_std),    32'(m_std));
      chk({ph, "/tr_ldd"},    32'(tr_ldd),    32'(m_ldd));
      chk({ph, "/stall"},     32'(stall),     32'(m_in | m_tr | m_ctx | m_halt));
      chk({ph, "/halted"},    32'(halted),    32'(m_halt));
      chk({ph, "/instr_cnt"}, 32'(instr_cnt), 32'(m_cnt));
      chk({ph, "/ctx_req"},   32'(ctx_req),   32'(m_ctx));
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic idle_inputs();
      rst_n = 1; halt = 0; go_t0 = 0; in_req = 0; enter = 0;
      tr_req = 0; tr_dir = 0; tr_done = 0; sched_en = 0; ctx_ack = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      step("reset");
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      m_pos = 0; m_cnt = 0;
      m_in = 0; m_tr = 0; m_ctx = 0; m_halt = 0; m_pend = 0; m_std = 0; m_ldd = 0;

      // reset state
      do_reset();
      chk("rst_t", 32'(t), 32'd1);
      chk("rst_cnt", 32'(instr_cnt), 32'd0);

      // free run through all T-states and wrap
      for (int i = 0; i < N_T; i++) begin
         step("run");
         chk("run_pos", 32'(t), 32'd1 << ((i + 1) % N_T));
      end
      chk("run_cnt", 32'(instr_cnt), 32'd1);

      // early retire at T3
      repeat (3) step("early");
      go_t0 = 1;
      step("early_go");
      go_t0 = 0;
      chk("early_t0", 32'(t), 32'd1);
      chk("early_cnt", 32'(instr_cnt), 32'd2);

      // input wait at T3 for 5 cycles
      repeat (3) step("in_adv");
      in_req = 1;
      step("in_stall");
      in_req = 0;
      repeat (4) begin
         step("in_hold");
         chk("in_hold_t", 32'(t), 32'd8);
         chk("in_hold_rd", 32'(read), 32'd1);
      end
      enter = 1;
      step("in_done");
      enter = 0;
      chk("in_done_t", 32'(t), 32'd16);
      chk("in_done_rd", 32'(read), 32'd0);

      // LDD transfer at T5 with go_t0 latched
      step("tr_adv");
      tr_req = 1; tr_dir = 1; go_t0 = 1;
      step("tr_start");
      tr_req = 0; tr_dir = 0; go_t0 = 0;
      chk("tr_ldd_pulse", 32'(tr_ldd), 32'd1);
      chk("tr_std_quiet", 32'(tr_std), 32'd0);
      repeat (3) begin
         step("tr_wait");
         chk("tr_wait_t", 32'(t), 32'd32);
         chk("tr_wait_ldd", 32'(tr_ldd), 32'd0);
      end
      tr_done = 1;
      step("tr_done");
      tr_done = 0;
      chk("tr_done_t", 32'(t), 32'd1);
      chk("tr_done_stall", 32'(stall), 32'd0);

      // STD transfer with done in the pulse cycle, no retire pending
      step("std_adv");
      tr_req = 1;
      step("std_start");
      tr_req = 0;
      chk("std_pulse", 32'(tr_std), 32'd1);
      tr_done = 1;
      step("std_done");
      tr_done = 0;
      chk("std_done_t", 32'(t), 32'd4);

      // quantum expiry with scheduling enabled
      sched_en = 1; go_t0 = 1;
      for (int k = 0; k < 20 && !m_ctx; k++) step("q_retire");
      go_t0 = 0;
      chk("q_ctx_req", 32'(ctx_req), 32'd1);
      chk("q_cnt_wrap", 32'(instr_cnt), 32'd0);
      repeat (3) begin
         step("q_hold");
         chk("q_hold_t", 32'(t), 32'd1);
      end
      ctx_ack = 1;
      step("q_ack");
      ctx_ack = 0;
      chk("q_ack_req", 32'(ctx_req), 32'd0);
      chk("q_ack_t", 32'(t), 32'd1);
      step("q_resume");
      chk("q_resume_t", 32'(t), 32'd2);

      // quantum expiry with scheduling disabled
      sched_en = 0; go_t0 = 1;
      repeat (QUANTUM) begin
         step("nq_retire");
         chk("nq_no_req", 32'(ctx_req), 32'd0);
      end
      go_t0 = 0;

      // halt at T2, sticky until reset
      do_reset();
      repeat (2) step("halt_adv");
      halt = 1;
      step("halt");
      halt = 0;
      chk("halt_t", 32'(t), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
      go_t0 = 1; tr_req = 1; in_req = 1;
      repeat (3) step("halt_stuck");
      idle_inputs();

      // reset while waiting on a transfer
      do_reset();
      tr_req = 1;
      step("rst_tr_start");
      tr_req = 0;
      do_reset();
      chk("rst_tr_t", 32'(t), 32'd1);
      chk("rst_tr_stall", 32'(stall), 32'd0);
      chk("rst_tr_std", 32'(tr_std | tr_ldd), 32'd0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         rst_n    = ($urandom_range(0, 299) != 0);
         halt     = ($urandom_range(0, 249) == 0);
         go_t0    = ($urandom_range(0, 5) == 0);
         in_req   = ($urandom_range(0, 7) == 0);
         enter    = ($urandom_range(0, 2) == 0);
         tr_req   = ($urandom_range(0, 7) == 0);
         tr_dir   = 1'($urandom_range(0, 1));
         tr_done  = ($urandom_range(0, 2) == 0);
         sched_en = ($urandom_range(0, 3) != 0);
         ctx_ack  = ($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
